// File: rtl/data_hs_pkg.sv
// Shared definitions for the valid/ready data handshake: FSM state encoding
// and the default abort timeout.
package data_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int TIMER_W         = 16;

endpackage

// File: rtl/data_master_if.sv
// Producer-side push port and receiver-side valid/ready port of data_master,
// plus its status outputs. master = the data_master side.
interface data_master_if #(
    parameter int width = 4,
    parameter int CNT_W = 8
);
    logic [width-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic [CNT_W-1:0] sent_cnt;
    logic             timeout_err;

    modport master (
        input  in_data, in_valid, ready,
        output in_ready, data, valid, busy, sent_cnt, timeout_err
    );

    modport slave (
        output in_data, in_valid, ready,
        input  in_ready, data, valid, busy, sent_cnt, timeout_err
    );
endinterface

// File: rtl/data_master_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data is the current head whenever !empty.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int width      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [width-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define
    // which entries are valid, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/data_master.sv
// Transmit end of the valid/ready handshake: buffers producer words and sends
// each one, waiting out the lagging ready. Optional SEND abort: DATA_MASTER_TIMEOUT_EN.
module data_master
    import data_hs_pkg::*;
#(
    parameter int width      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    data_master_if.master bus
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    hs_state_t        state, state_nxt;
    logic [width-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             launch;
    logic             ack;
    logic             abort;
    logic [width-1:0] data_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    sync_fifo #(
        .width      (width),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data (bus.in_data),
        .rd_en   (launch),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef DATA_MASTER_TIMEOUT_EN
    logic [TIMER_W-1:0] timer;
    logic               timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 timer <= '0;
        else if (launch)                         timer <= '0;
        else if (state == SEND && timer != '1)   timer <= timer + TIMER_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= abort;
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // NOTE: state register uses non-blocking assignment so every flop samples
    // pre-edge values; the next-state logic below stays purely combinational.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ack       = 1'b0;
        abort     = 1'b0;
        case (state)
            // A high ready here is the receiver still releasing the last word.
            IDLE: begin
                if (!fifo_empty && !bus.ready) begin
                    launch    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.ready) begin
                    ack       = 1'b1;
                    state_nxt = RELEASE;
                end
`ifdef DATA_MASTER_TIMEOUT_EN
                else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!bus.ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (launch) begin
                data_q  <= head;
                valid_q <= 1'b1;
            end else if (ack || abort) begin
                valid_q <= 1'b0;
            end
            if (ack) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready = ~fifo_full;
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign bus.sent_cnt = cnt_q;
    assign bus.busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_data_master.sv
// Bench for data_master: a registered receiver model, directed vector tables,
// a CNT_W=2 wrap instance and a randomized run scored against a word queue.
module tb_data_master;
    import data_hs_pkg::*;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_master_if #(.width(W), .CNT_W(CW)) bus  ();
    data_master_if #(.width(W), .CNT_W(2))  wbus ();

    data_master #(.width(W), .FIFO_DEPTH(D), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    data_master #(.width(W), .FIFO_DEPTH(D), .CNT_W(2), .TIMEOUT(TO)) u_wrap (
        .clk (clk), .rst (rst), .bus (wbus)
    );

    // Receiver model: valid registered once, ready one cycle after that.
    logic rx_en;
    logic rx_v;
    logic wrx_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_v      <= 1'b0;
            bus.ready <= 1'b0;
        end else begin
            rx_v      <= bus.valid;
            bus.ready <= rx_v & rx_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrx_v      <= 1'b0;
            wbus.ready <= 1'b0;
        end else begin
            wrx_v      <= wbus.valid;
            wbus.ready <= wrx_v;
        end
    end

    // Passive monitor: receiver captures, protocol violations, event counts.
    logic [W-1:0] rx_q[$];
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_data  = '0;
    int           stab_err   = 0;
    int           rise_err   = 0;
    int           rises      = 0;
    int           to_pulses  = 0;

    always @(negedge clk) begin
        if (bus.valid && bus.ready) rx_q.push_back(bus.data);
        if (prev_valid && bus.valid && bus.data !== prev_data) stab_err <= stab_err + 1;
        if (!prev_valid && bus.valid) begin
            rises <= rises + 1;
            if (bus.ready) rise_err <= rise_err + 1;
        end
        if (bus.timeout_err) to_pulses <= to_pulses + 1;
        prev_valid <= bus.valid;
        prev_data  <= bus.data;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((bus.busy || bus.ready) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check({name, " idle timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_wrap(input logic lvl, input string name);
        int n = 0;
        while (wbus.valid !== lvl && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({name, " wait timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0]  word;
        logic [W-1:0]  exp_data;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t         vecs[4];
    logic         bp_rdy[6];
    logic [1:0]   wrap_exp[5];
    logic [W-1:0] exp_q[$];
    int           exp_cnt;
    int           n;
    int           base;
    int           rises_before;

    initial begin
        vecs[0] = '{word: 4'hA, exp_data: 4'hA, exp_cnt: 8'd1};
        vecs[1] = '{word: 4'h5, exp_data: 4'h5, exp_cnt: 8'd2};
        vecs[2] = '{word: 4'h0, exp_data: 4'h0, exp_cnt: 8'd3};
        vecs[3] = '{word: 4'hF, exp_data: 4'hF, exp_cnt: 8'd4};
        bp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        wbus.in_valid = 1'b0;
        wbus.in_data  = '0;
        rx_en         = 1'b1;
        rst           = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset valid",       32'(bus.valid),       32'd0);
        check("reset data",        32'(bus.data),        32'd0);
        check("reset sent_cnt",    32'(bus.sent_cnt),    32'd0);
        check("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        check("reset in_ready",    32'(bus.in_ready),    32'd1);
        check("reset busy",        32'(bus.busy),        32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single words: two-edge latency, three-cycle valid, data held after.
        foreach (vecs[i]) begin
            wait_idle(50, "single");
            bus.in_data  = vecs[i].word;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            check("single valid after 1 edge", 32'(bus.valid), 32'd0);
            tick();
            check("single valid after 2 edges", 32'(bus.valid), 32'd1);
            check("single data", 32'(bus.data), 32'(vecs[i].exp_data));
            n = 1;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (!bus.valid) break;
                n++;
            end
            check("single valid width", 32'(n), 32'd3);
            check("single data held", 32'(bus.data), 32'(vecs[i].exp_data));
            check("single captured", 32'(rx_q[rx_q.size() - 1]), 32'(vecs[i].exp_data));
            check("single sent_cnt", 32'(bus.sent_cnt), 32'(vecs[i].exp_cnt));
        end
        exp_cnt = 4;

        // Burst of four back-to-back words.
        wait_idle(50, "burst");
        base = rx_q.size();
        for (int i = 1; i <= 4; i++) begin
            bus.in_data  = W'(i);
            bus.in_valid = 1'b1;
            check("burst in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_idle(200, "burst");
        check("burst count", 32'(rx_q.size() - base), 32'd4);
        for (int i = 0; i < 4 && base + i < rx_q.size(); i++)
            check("burst order", 32'(rx_q[base + i]), 32'(i + 1));
        exp_cnt += 4;
        check("burst sent_cnt", 32'(bus.sent_cnt), 32'(exp_cnt));
        check("burst valid re-rise under ready", 32'(rise_err), 32'd0);

        // Backpressure: ready withheld, four in FIFO plus one in SEND.
        base  = rx_q.size();
        rx_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_data  = W'(i + 5);
            bus.in_valid = 1'b1;
            check("backpressure in_ready", 32'(bus.in_ready), 32'(bp_rdy[i]));
            tick();
        end
        bus.in_valid = 1'b0;
        check("backpressure valid held", 32'(bus.valid), 32'd1);
        check("backpressure busy", 32'(bus.busy), 32'd1);
        rx_en = 1'b1;
        wait_idle(300, "backpressure");
        check("backpressure count", 32'(rx_q.size() - base), 32'd5);
        for (int i = 0; i < 5 && base + i < rx_q.size(); i++)
            check("backpressure order", 32'(rx_q[base + i]), 32'(i + 5));
        exp_cnt += 5;
        check("backpressure sent_cnt", 32'(bus.sent_cnt), 32'(exp_cnt));

        // Reset while a word is in SEND and more are queued.
        rx_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = W'(i + 1);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check("pre-reset valid", 32'(bus.valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid-send reset valid",    32'(bus.valid),    32'd0);
        check("mid-send reset sent_cnt", 32'(bus.sent_cnt), 32'd0);
        check("mid-send reset in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst   = 1'b0;
        rx_en = 1'b1;
        base         = rx_q.size();
        rises_before = rises;
        repeat (30) tick();
        check("post-reset no launch",  32'(rises - rises_before), 32'd0);
        check("post-reset no capture", 32'(rx_q.size() - base),   32'd0);
        check("post-reset busy",       32'(bus.busy),             32'd0);
        exp_cnt = 0;

        // Stalled SEND: aborts after TIMEOUT cycles only when compiled in.
        rx_en = 1'b0;
        base  = rx_q.size();
        bus.in_data  = 4'hC;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("stall valid rise", 32'(bus.valid), 32'd1);
        n = 1;
        for (int k = 0; k < 39; k++) begin
            tick();
            if (!bus.valid) break;
            n++;
        end
        repeat (3) tick();
`ifdef DATA_MASTER_TIMEOUT_EN
        check("timeout valid width", 32'(n), 32'(TO));
        check("timeout pulse count", 32'(to_pulses), 32'd1);
        check("timeout sent_cnt", 32'(bus.sent_cnt), 32'(exp_cnt));
        rx_en = 1'b1;
        wait_idle(50, "timeout");
        check("timeout word discarded", 32'(rx_q.size() - base), 32'd0);
`else
        check("no-timeout valid held", 32'(n), 32'd40);
        check("no-timeout pulse count", 32'(to_pulses), 32'd0);
        rx_en = 1'b1;
        wait_idle(50, "no-timeout");
        check("no-timeout captured", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) check("no-timeout word", 32'(rx_q[base]), 32'hC);
        exp_cnt += 1;
        check("no-timeout sent_cnt", 32'(bus.sent_cnt), 32'(exp_cnt));
`endif

        // sent_cnt wrap on the CNT_W=2 instance.
        for (int i = 0; i < 5; i++) begin
            wbus.in_data  = W'(i);
            wbus.in_valid = 1'b1;
            tick();
            wbus.in_valid = 1'b0;
            wait_wrap(1'b1, "wrap rise");
            wait_wrap(1'b0, "wrap fall");
            check("wrap sent_cnt", 32'(wbus.sent_cnt), 32'(wrap_exp[i]));
            repeat (4) tick();
        end

        // Randomized traffic with random receiver stalls.
        base = rx_q.size();
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = W'($urandom);
            rx_en        = ($urandom_range(0, 3) != 0);
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
            tick();
        end
        bus.in_valid = 1'b0;
        rx_en        = 1'b1;
        wait_idle(400, "random");
        check("random count", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < rx_q.size(); i++)
            check("random word", 32'(rx_q[base + i]), 32'(exp_q[i]));
        exp_cnt = (exp_cnt + exp_q.size()) % (1 << CW);
        check("random sent_cnt", 32'(bus.sent_cnt), 32'(exp_cnt));
        check("data stable under valid", 32'(stab_err), 32'd0);
        check("valid rise under ready",  32'(rise_err), 32'd0);
`ifndef DATA_MASTER_TIMEOUT_EN
        check("timeout_err tied low", 32'(to_pulses), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
